// File: rtl/huffman_alphabet_5_decoder_if.sv
// Handshake and config bundle for the serial Huffman decoder.
// Ports: cfg write path, code-bit stream in, symbol stream out, err/clr_err.
interface huffman_alphabet_5_decoder_if #(
  parameter int SYM_W = 5
);
  logic             cfg_we;
  logic             cfg_sel;
  logic [4:0]       cfg_addr;
  logic [5:0]       cfg_data;
  logic             in_valid;
  logic             in_bit;
  logic             in_ready;
  logic             sym_valid;
  logic [SYM_W-1:0] sym_data;
  logic [4:0]       sym_len;
  logic             sym_ready;
  logic             err;
  logic             clr_err;

  modport master (
    output cfg_we, cfg_sel, cfg_addr, cfg_data,
    output in_valid, in_bit, sym_ready, clr_err,
    input  in_ready, sym_valid, sym_data,
    input  sym_len, err
  );

  modport slave (
    input  cfg_we, cfg_sel, cfg_addr, cfg_data,
    input  in_valid, in_bit, sym_ready, clr_err,
    output in_ready, sym_valid, sym_data,
    output sym_len, err
  );
endinterface

// File: rtl/huffman_alphabet_5_decoder.sv
// Serial canonical-Huffman decoder, one code bit per cycle, MSB first.
// Ports: clock, rst_n (async low), bus (slave: cfg, bits in, symbols out, err).
module huffman_alphabet_5_decoder #(
  parameter int SYM_W   = 5,
  parameter int MAX_LEN = 16
) (
  input logic clock,
  input logic rst_n,
  huffman_alphabet_5_decoder_if.slave bus
);

  localparam int CW_W  = MAX_LEN + 1;
  localparam int LEN_W = 5;
  localparam int CNT_W = SYM_W + 1;
  localparam int LIX_W = $clog2(MAX_LEN);
  localparam int NSYM  = 1 << SYM_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DECODE,
    S_ERROR
  } state_t;

  state_t            state_q, state_d;
  logic [CW_W-1:0]   code_q, code_d;
  logic [CW_W-1:0]   first_q, first_d;
  logic [SYM_W-1:0]  index_q, index_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              sym_valid_q, sym_valid_d;
  logic [SYM_W-1:0]  sym_data_q, sym_data_d;
  logic [LEN_W-1:0]  sym_len_q, sym_len_d;
  logic              err_q, err_d;

  logic [CNT_W-1:0]  cnt_q [MAX_LEN];
  logic [SYM_W-1:0]  sym_q [NSYM];

  logic              in_ready;
  logic              accept;
  logic [LEN_W-1:0]  len_nx;
  logic [CW_W-1:0]   cw;
  logic [CNT_W-1:0]  c;
  logic [CW_W-1:0]   c_ext;
  logic [CW_W-1:0]   diff;
  logic              hit;
  logic [SYM_W-1:0]  sidx;

  assign in_ready = (state_q != S_ERROR)
                  & ~(sym_valid_q & ~bus.sym_ready)
                  & ~bus.cfg_we;
  assign accept   = bus.in_valid & in_ready;

  // Length MAX_LEN wraps to count-table slot 0.
  assign len_nx = len_q + LEN_W'(1);
  assign cw     = code_q | CW_W'(bus.in_bit);
  assign c      = cnt_q[len_nx[LIX_W-1:0]];
  assign c_ext  = CW_W'(c);
  assign diff   = cw - first_q;
  assign hit    = (cw >= first_q) && (diff < c_ext);
  assign sidx   = index_q + diff[SYM_W-1:0];

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_LEN; i++) cnt_q[i] <= '0;
      for (int i = 0; i < NSYM; i++) sym_q[i] <= '0;
    end else if (bus.cfg_we) begin
      if (!bus.cfg_sel) begin
        if (bus.cfg_addr < LEN_W'(MAX_LEN))
          cnt_q[bus.cfg_addr[LIX_W-1:0]] <= bus.cfg_data;
      end else begin
        sym_q[bus.cfg_addr[SYM_W-1:0]] <= bus.cfg_data[SYM_W-1:0];
      end
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      code_q      <= '0;
      first_q     <= '0;
      index_q     <= '0;
      len_q       <= '0;
      sym_valid_q <= 1'b0;
      sym_data_q  <= '0;
      sym_len_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      code_q      <= code_d;
      first_q     <= first_d;
      index_q     <= index_d;
      len_q       <= len_d;
      sym_valid_q <= sym_valid_d;
      sym_data_q  <= sym_data_d;
      sym_len_q   <= sym_len_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    code_d      = code_q;
    first_d     = first_q;
    index_d     = index_q;
    len_d       = len_q;
    sym_valid_d = sym_valid_q;
    sym_data_d  = sym_data_q;
    sym_len_d   = sym_len_q;
    err_d       = err_q;

    if (sym_valid_q && bus.sym_ready)
      sym_valid_d = 1'b0;

    if (bus.clr_err || bus.cfg_we) begin
      state_d = S_IDLE;
      code_d  = '0;
      first_d = '0;
      index_d = '0;
      len_d   = '0;
      if (bus.clr_err) err_d = 1'b0;
    end else if (accept) begin
      if (hit) begin
        sym_data_d  = sym_q[sidx];
        sym_len_d   = len_nx;
        sym_valid_d = 1'b1;
        state_d     = S_IDLE;
        code_d      = '0;
        first_d     = '0;
        index_d     = '0;
        len_d       = '0;
      end else if (len_nx == LEN_W'(MAX_LEN)) begin
        state_d = S_ERROR;
        err_d   = 1'b1;
      end else begin
        index_d = index_q + c[SYM_W-1:0];
        first_d = (first_q + c_ext) << 1;
        code_d  = cw << 1;
        len_d   = len_nx;
        state_d = S_DECODE;
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.sym_valid = sym_valid_q;
  assign bus.sym_data  = sym_data_q;
  assign bus.sym_len   = sym_len_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_huffman_alphabet_5_decoder.sv
// Bench for the serial Huffman decoder: directed scenarios plus random
// canonical tables checked against a codeword-list reference model.
module tb_huffman_alphabet_5_decoder;

  logic clock = 1'b0;
  logic rst_n = 1'b0;
  int   passed = 0;
  int   total  = 0;

  always #5 clock = ~clock;

  huffman_alphabet_5_decoder_if bus ();

  huffman_alphabet_5_decoder dut (
    .clock(clock),
    .rst_n(rst_n),
    .bus  (bus)
  );

  task automatic idle_inputs();
    bus.cfg_we    = 1'b0;
    bus.cfg_sel   = 1'b0;
    bus.cfg_addr  = '0;
    bus.cfg_data  = '0;
    bus.in_valid  = 1'b0;
    bus.in_bit    = 1'b0;
    bus.sym_ready = 1'b1;
    bus.clr_err   = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    rst_n = 1'b0;
    @(negedge clock);
    rst_n = 1'b1;
  endtask

  task automatic cfg_write(input logic sel, input int addr,
                           input int data);
    @(negedge clock);
    bus.cfg_we   = 1'b1;
    bus.cfg_sel  = sel;
    bus.cfg_addr = 5'(addr);
    bus.cfg_data = 6'(data);
    @(posedge clock);
    #1;
    bus.cfg_we = 1'b0;
  endtask

  task automatic drive_bit(input logic b);
    @(negedge clock);
    bus.in_valid = 1'b1;
    bus.in_bit   = b;
    @(posedge clock);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic load_basic();
    int syms[5];
    syms = '{7, 3, 20, 0, 31};
    cfg_write(1'b0, 2, 3);
    cfg_write(1'b0, 3, 2);
    for (int i = 0; i < 5; i++) cfg_write(1'b1, i, syms[i]);
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.sym_valid !== 1'b0 || bus.err !== 1'b0) begin
      $display("FAIL reset_flags: valid=%b err=%b want 0 0",
               bus.sym_valid, bus.err);
    end else passed++;
    total++;
    if (bus.sym_data !== 5'd0 || bus.sym_len !== 5'd0) begin
      $display("FAIL reset_data: data=%0d len=%0d want 0 0",
               bus.sym_data, bus.sym_len);
    end else passed++;
    @(negedge clock);
    rst_n = 1'b1;
    #1;
    total++;
    if (bus.in_ready !== 1'b1) begin
      $display("FAIL reset_ready: in_ready=%b want 1", bus.in_ready);
    end else passed++;
  endtask

  task automatic test_basic();
    load_basic();
    bus.sym_ready = 1'b1;
    drive_bit(1'b0);
    total++;
    if (bus.sym_valid !== 1'b0) begin
      $display("FAIL basic_partial: valid=%b want 0", bus.sym_valid);
    end else passed++;
    drive_bit(1'b1);
    total++;
    if (bus.sym_valid !== 1'b1 || bus.sym_data !== 5'd3 ||
        bus.sym_len !== 5'd2) begin
      $display("FAIL basic_sym: v=%b d=%0d l=%0d want 1 3 2",
               bus.sym_valid, bus.sym_data, bus.sym_len);
    end else passed++;
    @(posedge clock);
    #1;
    total++;
    if (bus.sym_valid !== 1'b0) begin
      $display("FAIL basic_drop: valid=%b want 0", bus.sym_valid);
    end else passed++;
  endtask

  task automatic test_stream();
    logic b[8];
    logic ev[8];
    int   ed[8];
    int   el[8];
    b  = '{1, 1, 1, 1, 1, 0, 0, 0};
    ev = '{0, 0, 1, 0, 0, 1, 0, 1};
    ed = '{0, 0, 31, 0, 0, 0, 0, 7};
    el = '{0, 0, 3, 0, 0, 3, 0, 2};
    bus.sym_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive_bit(b[i]);
      total++;
      if (bus.sym_valid !== ev[i] || (ev[i] &&
          (bus.sym_data !== 5'(ed[i]) || bus.sym_len !== 5'(el[i]))))
      begin
        $display("FAIL stream_%0d: v=%b d=%0d l=%0d want %b %0d %0d",
                 i, bus.sym_valid, bus.sym_data, bus.sym_len,
                 ev[i], ed[i], el[i]);
      end else passed++;
    end
  endtask

  task automatic test_backpressure();
    @(negedge clock);
    bus.sym_ready = 1'b1;
    @(negedge clock);
    bus.sym_ready = 1'b0;
    drive_bit(1'b1);
    drive_bit(1'b1);
    drive_bit(1'b1);
    @(negedge clock);
    bus.in_valid = 1'b1;
    bus.in_bit   = 1'b1;
    #1;
    total++;
    if (bus.in_ready !== 1'b0) begin
      $display("FAIL bp_ready_low: in_ready=%b want 0", bus.in_ready);
    end else passed++;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock);
      #1;
      total++;
      if (bus.sym_valid !== 1'b1 || bus.sym_data !== 5'd31 ||
          bus.sym_len !== 5'd3) begin
        $display("FAIL bp_hold_%0d: v=%b d=%0d l=%0d want 1 31 3",
                 i, bus.sym_valid, bus.sym_data, bus.sym_len);
      end else passed++;
    end
    @(negedge clock);
    bus.sym_ready = 1'b1;
    #1;
    total++;
    if (bus.in_ready !== 1'b1) begin
      $display("FAIL bp_ready_high: in_ready=%b want 1", bus.in_ready);
    end else passed++;
    @(posedge clock);
    #1;
    bus.in_valid = 1'b0;
    total++;
    if (bus.sym_valid !== 1'b0) begin
      $display("FAIL bp_handoff: valid=%b want 0", bus.sym_valid);
    end else passed++;
    drive_bit(1'b1);
    drive_bit(1'b0);
    total++;
    if (bus.sym_valid !== 1'b1 || bus.sym_data !== 5'd0 ||
        bus.sym_len !== 5'd3) begin
      $display("FAIL bp_resume: v=%b d=%0d l=%0d want 1 0 3",
               bus.sym_valid, bus.sym_data, bus.sym_len);
    end else passed++;
  endtask

  task automatic test_error();
    idle_inputs();
    do_reset();
    cfg_write(1'b0, 1, 1);
    cfg_write(1'b1, 0, 9);
    for (int i = 0; i < 16; i++) begin
      drive_bit(1'b1);
      if (i == 14) begin
        total++;
        if (bus.err !== 1'b0) begin
          $display("FAIL err_early: err=%b want 0", bus.err);
        end else passed++;
      end
    end
    total++;
    if (bus.err !== 1'b1 || bus.sym_valid !== 1'b0) begin
      $display("FAIL err_set: err=%b valid=%b want 1 0",
               bus.err, bus.sym_valid);
    end else passed++;
    @(negedge clock);
    bus.in_valid = 1'b1;
    #1;
    total++;
    if (bus.in_ready !== 1'b0) begin
      $display("FAIL err_ready: in_ready=%b want 0", bus.in_ready);
    end else passed++;
    bus.in_valid = 1'b0;
    bus.clr_err  = 1'b1;
    @(posedge clock);
    #1;
    bus.clr_err = 1'b0;
    total++;
    if (bus.err !== 1'b0) begin
      $display("FAIL err_clear: err=%b want 0", bus.err);
    end else passed++;
    for (int i = 0; i < 3; i++) begin
      drive_bit(1'b0);
      total++;
      if (bus.sym_valid !== 1'b1 || bus.sym_data !== 5'd9 ||
          bus.sym_len !== 5'd1 || bus.err !== 1'b0) begin
        $display("FAIL err_one_bit_%0d: v=%b d=%0d l=%0d e=%b want 1 9 1 0",
                 i, bus.sym_valid, bus.sym_data, bus.sym_len, bus.err);
      end else passed++;
    end
    @(posedge clock);
    #1;
    @(negedge clock);
    bus.clr_err  = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_bit   = 1'b0;
    @(posedge clock);
    #1;
    bus.clr_err  = 1'b0;
    bus.in_valid = 1'b0;
    total++;
    if (bus.sym_valid !== 1'b0) begin
      $display("FAIL clr_priority: valid=%b want 0", bus.sym_valid);
    end else passed++;
  endtask

  task automatic test_flush();
    idle_inputs();
    do_reset();
    load_basic();
    drive_bit(1'b1);
    drive_bit(1'b1);
    cfg_write(1'b1, 0, 7);
    total++;
    if (bus.sym_valid !== 1'b0) begin
      $display("FAIL flush_none: valid=%b want 0", bus.sym_valid);
    end else passed++;
    drive_bit(1'b0);
    drive_bit(1'b1);
    total++;
    if (bus.sym_valid !== 1'b1 || bus.sym_data !== 5'd3 ||
        bus.sym_len !== 5'd2) begin
      $display("FAIL flush_sym: v=%b d=%0d l=%0d want 1 3 2",
               bus.sym_valid, bus.sym_data, bus.sym_len);
    end else passed++;
  endtask

  task automatic test_async_reset();
    idle_inputs();
    do_reset();
    load_basic();
    bus.sym_ready = 1'b0;
    drive_bit(1'b0);
    drive_bit(1'b1);
    total++;
    if (bus.sym_valid !== 1'b1 || bus.sym_data !== 5'd3) begin
      $display("FAIL areset_pre: v=%b d=%0d want 1 3",
               bus.sym_valid, bus.sym_data);
    end else passed++;
    @(posedge clock);
    #3;
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.sym_valid !== 1'b0 || bus.sym_data !== 5'd0 ||
        bus.sym_len !== 5'd0 || bus.err !== 1'b0) begin
      $display("FAIL areset_out: v=%b d=%0d l=%0d e=%b want 0 0 0 0",
               bus.sym_valid, bus.sym_data, bus.sym_len, bus.err);
    end else passed++;
    @(negedge clock);
    rst_n = 1'b1;
    bus.sym_ready = 1'b1;
    drive_bit(1'b0);
    drive_bit(1'b1);
    total++;
    if (bus.sym_valid !== 1'b0) begin
      $display("FAIL areset_tables: valid=%b want 0", bus.sym_valid);
    end else passed++;
  endtask

  task automatic test_random(input int rounds);
    int         lens[$];
    int         cnt[17];
    logic [4:0] st[32];
    logic [16:0] cwc[32];
    int         cwl[32];
    logic [16:0] code;
    logic       bitsq[$];
    int         exp_sym[$];
    int         exp_len[$];
    int         target, guard, j, l, n, cyc, pick;
    for (int r = 0; r < rounds; r++) begin
      lens = '{1, 1};
      target = $urandom_range(2, 32);
      guard = 0;
      while (lens.size() < target && guard < 2000) begin
        guard++;
        j = $urandom_range(0, lens.size() - 1);
        if (lens[j] < 16) begin
          l = lens[j];
          lens.delete(j);
          lens.push_back(l + 1);
          lens.push_back(l + 1);
        end
      end
      for (int k = 0; k < 17; k++) cnt[k] = 0;
      foreach (lens[k]) cnt[lens[k]]++;
      idle_inputs();
      do_reset();
      for (int k = 1; k <= 16; k++)
        cfg_write(1'b0, (k == 16) ? 0 : k, cnt[k]);
      for (int k = 0; k < 32; k++) begin
        st[k] = 5'($urandom);
        cfg_write(1'b1, k, int'(st[k]));
      end
      code = '0;
      n = 0;
      for (int k = 1; k <= 16; k++) begin
        for (int m = 0; m < cnt[k]; m++) begin
          cwc[n] = code;
          cwl[n] = k;
          code = code + 17'd1;
          n++;
        end
        code = code << 1;
      end
      bitsq.delete();
      exp_sym.delete();
      exp_len.delete();
      for (int s = 0; s < 40; s++) begin
        pick = $urandom_range(0, n - 1);
        for (int b = cwl[pick] - 1; b >= 0; b--)
          bitsq.push_back(cwc[pick][b]);
        exp_sym.push_back(int'(st[pick]));
        exp_len.push_back(cwl[pick]);
      end
      cyc = 0;
      while ((bitsq.size() > 0 || exp_sym.size() > 0) && cyc < 6000) begin
        cyc++;
        @(negedge clock);
        bus.in_valid  = (bitsq.size() > 0) && ($urandom_range(0, 3) != 0);
        bus.in_bit    = (bitsq.size() > 0) ? bitsq[0] : 1'b0;
        bus.sym_ready = ($urandom_range(0, 2) != 0);
        #1;
        if (bus.in_valid && bus.in_ready) void'(bitsq.pop_front());
        if (bus.sym_valid && bus.sym_ready) begin
          total++;
          if (exp_sym.size() == 0) begin
            $display("FAIL rand_extra: got d=%0d l=%0d want none",
                     bus.sym_data, bus.sym_len);
          end else begin
            if (bus.sym_data !== 5'(exp_sym[0]) ||
                bus.sym_len !== 5'(exp_len[0])) begin
              $display("FAIL rand_sym: got d=%0d l=%0d want %0d %0d",
                       bus.sym_data, bus.sym_len, exp_sym[0], exp_len[0]);
            end else passed++;
            void'(exp_sym.pop_front());
            void'(exp_len.pop_front());
          end
        end
      end
      bus.in_valid  = 1'b0;
      bus.sym_ready = 1'b1;
      if (bitsq.size() > 0 || exp_sym.size() > 0) begin
        total++;
        $display("FAIL rand_timeout: bits=%0d syms=%0d left, want 0 0",
                 bitsq.size(), exp_sym.size());
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stream();
    test_backpressure();
    test_error();
    test_flush();
    test_async_reset();
    test_random(4);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
